// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide unit for the EX stage.
// Handles one M-type operation at a time, one bit per cycle: shift-add for
// the multiplies and restoring division for the divides. It stalls the
// pipeline while busy, then presents the result with a one-cycle done pulse.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           M-type instruction present in EX
//   func3           0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//   op_a, op_b      rs1 / rs2 after forwarding
//   flush           abort the operation in flight (taken branch/jump)
//   busy            FSM is not in IDLE (registered)
//   stall           freeze IF/ID/EX (combinational, includes the accept cycle)
//   done            result valid this cycle (registered)
//   result          last completed result (registered, held until the next one)
module muldiv_seq #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam int unsigned AW = 2 * XLEN;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] a_q, b_q;      // raw operands until PREP, magnitudes afterwards
  logic [AW-1:0]   acc_q;         // product, or {remainder, quotient}
  logic [CW-1:0]   cnt_q;
  logic            neg_a_q, neg_b_q;

  logic            signed_a_c, signed_b_c, neg_a_c, neg_b_c;
  logic [AW-1:0]   mul_step_c, div_step_c, prod_c;
  logic [XLEN:0]   rem_sh_c, diff_c;
  logic            ge_c;
  logic [XLEN-1:0] quo_c, rem_c, fix_c;

  // Operand signedness and magnitude sign flags.
  always_comb begin
    signed_a_c = (f3_q != 3'd3) && (f3_q != 3'd5) && (f3_q != 3'd7);
    signed_b_c = signed_a_c && (f3_q != 3'd2);
    neg_a_c    = signed_a_c && a_q[XLEN-1];
    neg_b_c    = signed_b_c && b_q[XLEN-1];
  end

  // One iteration step, MSB first for both multiply and divide.
  always_comb begin
    mul_step_c = {acc_q[AW-2:0], 1'b0} + (b_q[cnt_q] ? {{XLEN{1'b0}}, a_q} : {AW{1'b0}});
    rem_sh_c   = {acc_q[AW-1:XLEN], a_q[cnt_q]};
    ge_c       = (rem_sh_c >= {1'b0, b_q});
    diff_c     = rem_sh_c - {1'b0, b_q};
    // A zero divisor always "fits", giving an all-ones quotient and remainder = |a|.
    div_step_c = {XLEN'(ge_c ? diff_c : rem_sh_c), acc_q[XLEN-2:0], ge_c};
  end

  // Sign correction and result word selection.
  always_comb begin
    prod_c = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    quo_c  = ((neg_a_q ^ neg_b_q) && (b_q != '0)) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_c  = neg_a_q ? -acc_q[AW-1:XLEN] : acc_q[AW-1:XLEN];
    if (f3_q[2]) begin
      fix_c = f3_q[1] ? rem_c : quo_c;
    end else begin
      fix_c = (f3_q[1:0] == 2'b00) ? prod_c[XLEN-1:0] : prod_c[AW-1:XLEN];
    end
  end

  // State register plus registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != S_IDLE);
      done  <= (state_nxt == S_DONE);
    end
  end

  // Next-state and stall.
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !flush) begin
          state_nxt = S_PREP;
          stall     = 1'b1;
        end
      end
      S_PREP: begin
        state_nxt = S_CALC;
        stall     = 1'b1;
      end
      S_CALC: begin
        stall = 1'b1;
        if (cnt_q == '0) state_nxt = S_FIX;
      end
      S_FIX: begin
        stall     = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (flush && (state != S_IDLE)) state_nxt = S_IDLE;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f3_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      result  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !flush) begin
            f3_q <= func3;
            a_q  <= op_a;
            b_q  <= op_b;
          end
        end
        S_PREP: begin
          neg_a_q <= neg_a_c;
          neg_b_q <= neg_b_c;
          a_q     <= neg_a_c ? -a_q : a_q;
          b_q     <= neg_b_c ? -b_q : b_q;
          cnt_q   <= CW'(XLEN - 1);
          acc_q   <= '0;
        end
        S_CALC: begin
          acc_q <= f3_q[2] ? div_step_c : mul_step_c;
          cnt_q <= cnt_q - CW'(1);
        end
        S_FIX: begin
          if (!flush) result <= fix_c;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: the driver pushes hand-computed results,
// a negedge monitor pops and compares on every done pulse.
module tb_muldiv_seq;
  localparam int unsigned XLEN = 32;
  localparam int unsigned LAT  = XLEN + 3;  // done is in the 35th cycle after the start edge

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            flush = 1'b0;
  logic [2:0]      func3 = '0;
  logic [XLEN-1:0] op_a = '0;
  logic [XLEN-1:0] op_b = '0;
  logic            busy, stall, done;
  logic [XLEN-1:0] result;

  typedef struct {
    logic [XLEN-1:0] res;
    int              start_cyc;
    string           name;
  } exp_t;

  exp_t            sb[$];
  exp_t            mon_e;
  int              n_cmp = 0, n_err = 0, n_done = 0, n_exp = 0, cyc = 0;
  logic [XLEN-1:0] last_res = '0;

  muldiv_seq #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .func3(func3), .op_a(op_a), .op_b(op_b),
    .flush(flush), .busy(busy), .stall(stall), .done(done), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      n_done++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: result %h with nothing pending", result);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, " result"}, result, mon_e.res);
        check({mon_e.name, " latency"}, XLEN'(cyc - mon_e.start_cyc + 1), XLEN'(LAT));
      end
    end
  end

  // Present one instruction for one cycle, then scramble the inputs.
  task automatic issue(input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] exp, input string nm, input bit push);
    exp_t e;
    @(negedge clk);
    start = 1'b1; func3 = f; op_a = a; op_b = b;
    if (push) begin
      e.res = exp; e.start_cyc = cyc + 1; e.name = nm;
      sb.push_back(e);
      n_exp++;
    end
    #1 check({nm, " stall_at_start"}, XLEN'(stall), XLEN'(1));
    @(posedge clk);
    #1;
    start = 1'b0; func3 = 3'd0; op_a = '1; op_b = '1;
  endtask

  // Wait for done with a cycle budget; optionally pulse start at cycle inj.
  task automatic finish_op(input string nm, input int inj);
    bit seen = 1'b0;
    bit held = 1'b1;
    for (int i = 1; i <= int'(LAT) + 10; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (!stall || !busy) held = 1'b0;
      start = (i == inj);
      if (i == inj) begin
        func3 = 3'd0; op_a = 32'h0000_1234; op_b = 32'h0000_5678;
      end
    end
    start = 1'b0;
    check({nm, " stall_held"}, XLEN'(held), XLEN'(1));
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s timeout: no done within %0d cycles", nm, LAT + 10);
    end else begin
      check({nm, " stall_in_done"}, XLEN'(stall), XLEN'(0));
      check({nm, " busy_in_done"}, XLEN'(busy), XLEN'(1));
    end
  endtask

  task automatic op(input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                    input logic [XLEN-1:0] exp, input string nm);
    issue(f, a, b, exp, nm, 1'b1);
    finish_op(nm, 0);
    last_res = exp;
  endtask

  initial begin
    #2;
    check("reset busy", XLEN'(busy), XLEN'(0));
    check("reset done", XLEN'(done), XLEN'(0));
    check("reset result", result, '0);
    #10 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle busy", XLEN'(busy), XLEN'(0));

    // Multiplies
    op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7_m3");
    op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max");
    op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min_min");
    op(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, "mulhsu_m1_2");
    op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "mul_m1_m1");
    op(3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, "mulh_m2_3");
    // Divides
    op(3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, "div_m7_2");
    op(3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, "rem_m7_2");
    op(3'd5, 32'hFFFF_FFFE, 32'h0000_0003, 32'h5555_5554, "divu_big_3");
    op(3'd7, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, "remu_100_7");
    // Division corners
    op(3'd4, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, "div_by_zero");
    op(3'd6, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, "rem_by_zero");
    op(3'd5, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, "divu_by_zero");
    op(3'd6, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, "rem_neg_by_zero");
    op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_overflow");
    op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "rem_overflow");

    // Second start at CALC cycle 10 (11th cycle after the start edge) is ignored.
    issue(3'd0, 32'h0000_0006, 32'h0000_0007, 32'h0000_002A, "mul_ignore_start", 1'b1);
    finish_op("mul_ignore_start", 11);
    last_res = 32'h0000_002A;
    repeat (LAT + 5) @(negedge clk);

    // Flush at CALC cycle 5: back to IDLE, no done, result retained.
    issue(3'd5, 32'h0000_03E8, 32'h0000_0003, '0, "divu_flushed", 1'b0);
    repeat (6) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush busy", XLEN'(busy), XLEN'(0));
    check("flush stall", XLEN'(stall), XLEN'(0));
    check("flush result", result, last_res);
    repeat (LAT + 5) @(negedge clk);
    check("flush result_later", result, last_res);

    // Flush together with start in IDLE: not accepted.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; func3 = 3'd0; op_a = 32'd3; op_b = 32'd3;
    #1 check("flush_start stall", XLEN'(stall), XLEN'(0));
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_start busy", XLEN'(busy), XLEN'(0));

    // Reset mid-CALC: asynchronous clear, no done afterwards.
    issue(3'd0, 32'h0000_0009, 32'h0000_0009, '0, "mul_reset", 1'b0);
    repeat (12) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset busy", XLEN'(busy), XLEN'(0));
    check("async_reset done", XLEN'(done), XLEN'(0));
    check("async_reset result", result, '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 5) @(negedge clk);
    check("post_reset busy", XLEN'(busy), XLEN'(0));
    check("post_reset result", result, '0);

    check("done_count", XLEN'(n_done), XLEN'(n_exp));
    check("pending_left", XLEN'(sb.size()), XLEN'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
